// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: bus widths, access-FSM state
// encoding and requester identifiers.
package sram_arbiter_pkg;

  localparam int SRAM_ADDR_W = 21;
  localparam int SRAM_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD        = 3'd1,
    WR_SETUP  = 3'd2,
    WR_STROBE = 3'd3,
    WR_HOLD   = 3'd4
  } state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_VID = 1'b1
  } req_id_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundle of the CPU, video and SRAM-pin signals around the arbiter.
// slave = arbiter side, master = requesters plus the SRAM/pad side.
interface sram_arbiter_if
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_rdata;
  logic              vid_ack;

  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_dout;
  logic              sram_doe;
  logic [DATA_W-1:0] sram_din;
  logic              sram_we_n;

  logic              busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  vid_req, vid_addr,
    output vid_rdata, vid_ack,
    output sram_addr, sram_dout, sram_doe, sram_we_n,
    input  sram_din,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output vid_req, vid_addr,
    input  vid_rdata, vid_ack,
    input  sram_addr, sram_dout, sram_doe, sram_we_n,
    output sram_din,
    input  busy
  );

endinterface

// File: rtl/sram_arb_pick.sv
// Winner selection for the SRAM arbiter. Video has priority, but after
// MAX_CPU_WAIT consecutive video grants with the CPU pending, the CPU wins.
module sram_arb_pick
  import sram_arbiter_pkg::*;
#(
  parameter int MAX_CPU_WAIT = 4
) (
  input  logic    clk_chipset,
  input  logic    reset_n,
  input  logic    i_cpu_req,
  input  logic    i_vid_req,
  input  logic    i_grant_en,
  output logic    o_grant,
  output req_id_t o_winner
);

  localparam int WAIT_W = $clog2(MAX_CPU_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_CPU_WAIT);

  logic [WAIT_W-1:0] r_cpu_wait;
  logic              w_cpu_forced;

  // Pick a winner among the pending requests while the FSM can accept one.
  always_comb begin
    w_cpu_forced = i_cpu_req && (r_cpu_wait == WAIT_MAX);
    o_grant      = i_grant_en && (i_cpu_req || i_vid_req);
    o_winner     = REQ_CPU;
    if (i_vid_req && !w_cpu_forced) begin
      o_winner = REQ_VID;
    end
  end

  // Count video grants that overtook a pending CPU; clear on a CPU grant.
  always_ff @(posedge clk_chipset or negedge reset_n) begin
    if (!reset_n) begin
      r_cpu_wait <= '0;
    end else if (o_grant) begin
      if (o_winner == REQ_CPU) begin
        r_cpu_wait <= '0;
      end else if (i_cpu_req && (r_cpu_wait != WAIT_MAX)) begin
        r_cpu_wait <= r_cpu_wait + WAIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Access FSM that owns the asynchronous SRAM pins and serves the CPU and
// video requesters with fixed, parameterised strobe timing.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | no access; grants a request unless an ack is being shown
//   RD        | read address held ACCESS_CYCLES cycles, sample on the last
//   WR_SETUP  | address/data driven, WE_n still high
//   WR_STROBE | WE_n low for ACCESS_CYCLES cycles
//   WR_HOLD   | WE_n high, data still driven, cpu_ack shown
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W        = SRAM_ADDR_W,
  parameter int DATA_W        = SRAM_DATA_W,
  parameter int ACCESS_CYCLES = 2,
  parameter int MAX_CPU_WAIT  = 4
) (
  input  logic           clk_chipset,
  input  logic           reset_n,
  sram_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_t            r_state, w_state_nxt;
  req_id_t           r_owner, w_owner_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_dout, w_dout_nxt;
  logic              r_doe, w_doe_nxt;
  logic              r_we_n, w_we_n_nxt;
  logic [DATA_W-1:0] r_cpu_rdata, w_cpu_rdata_nxt;
  logic [DATA_W-1:0] r_vid_rdata, w_vid_rdata_nxt;
  logic              r_cpu_ack, w_cpu_ack_nxt;
  logic              r_vid_ack, w_vid_ack_nxt;
  logic              r_busy, w_busy_nxt;

  logic              w_grant_en;
  logic              w_grant;
  req_id_t           w_winner;

  // A request seen during an ack cycle is the one just served; the
  // requester only gets to drop it in the following cycle.
  assign w_grant_en = (r_state == IDLE) && !r_cpu_ack && !r_vid_ack;

  sram_arb_pick #(
    .MAX_CPU_WAIT (MAX_CPU_WAIT)
  ) u_pick (
    .clk_chipset (clk_chipset),
    .reset_n     (reset_n),
    .i_cpu_req   (bus.cpu_req),
    .i_vid_req   (bus.vid_req),
    .i_grant_en  (w_grant_en),
    .o_grant     (w_grant),
    .o_winner    (w_winner)
  );

  // Next-state and next-output decode for the access FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_cnt_nxt       = r_cnt;
    w_addr_nxt      = r_addr;
    w_dout_nxt      = r_dout;
    w_doe_nxt       = r_doe;
    w_we_n_nxt      = r_we_n;
    w_cpu_rdata_nxt = r_cpu_rdata;
    w_vid_rdata_nxt = r_vid_rdata;
    w_cpu_ack_nxt   = 1'b0;
    w_vid_ack_nxt   = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_owner_nxt = w_winner;
          w_cnt_nxt   = CNT_LOAD;
          if (w_winner == REQ_VID) begin
            w_addr_nxt  = bus.vid_addr;
            w_state_nxt = RD;
          end else begin
            w_addr_nxt = bus.cpu_addr;
            if (bus.cpu_we) begin
              w_dout_nxt  = bus.cpu_wdata;
              w_doe_nxt   = 1'b1;
              w_state_nxt = WR_SETUP;
            end else begin
              w_state_nxt = RD;
            end
          end
        end
      end

      RD: begin
        if (r_cnt == CNT_LAST) begin
          if (r_owner == REQ_VID) begin
            w_vid_rdata_nxt = bus.sram_din;
            w_vid_ack_nxt   = 1'b1;
          end else begin
            w_cpu_rdata_nxt = bus.sram_din;
            w_cpu_ack_nxt   = 1'b1;
          end
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      WR_SETUP: begin
        w_we_n_nxt  = 1'b0;
        w_state_nxt = WR_STROBE;
      end

      WR_STROBE: begin
        if (r_cnt == CNT_LAST) begin
          w_we_n_nxt    = 1'b1;
          w_cpu_ack_nxt = 1'b1;
          w_state_nxt   = WR_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      WR_HOLD: begin
        w_doe_nxt   = 1'b0;
        w_state_nxt = IDLE;
      end

      default: begin
        w_we_n_nxt  = 1'b1;
        w_doe_nxt   = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // State and output registers; reset parks the pins in a safe idle state.
  always_ff @(posedge clk_chipset or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_owner     <= REQ_CPU;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_dout      <= '0;
      r_doe       <= 1'b0;
      r_we_n      <= 1'b1;
      r_cpu_rdata <= '0;
      r_vid_rdata <= '0;
      r_cpu_ack   <= 1'b0;
      r_vid_ack   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_cnt       <= w_cnt_nxt;
      r_addr      <= w_addr_nxt;
      r_dout      <= w_dout_nxt;
      r_doe       <= w_doe_nxt;
      r_we_n      <= w_we_n_nxt;
      r_cpu_rdata <= w_cpu_rdata_nxt;
      r_vid_rdata <= w_vid_rdata_nxt;
      r_cpu_ack   <= w_cpu_ack_nxt;
      r_vid_ack   <= w_vid_ack_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign bus.sram_addr = r_addr;
  assign bus.sram_dout = r_dout;
  assign bus.sram_doe  = r_doe;
  assign bus.sram_we_n = r_we_n;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.vid_rdata = r_vid_rdata;
  assign bus.cpu_ack   = r_cpu_ack;
  assign bus.vid_ack   = r_vid_ack;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter at default parameters. Cycle k is the
// k-th clock period after the IDLE cycle in which the request is presented;
// outputs are sampled on the falling edge.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int ADDR_W = 21;
  localparam int DATA_W = 8;

  logic clk_chipset = 1'b0;
  logic reset_n     = 1'b0;

  sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_arbiter #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .ACCESS_CYCLES (2),
    .MAX_CPU_WAIT  (4)
  ) dut (
    .clk_chipset (clk_chipset),
    .reset_n     (reset_n),
    .bus         (bus)
  );

  always #10 clk_chipset = ~clk_chipset;

  int n_cmp = 0;
  int n_bad = 0;

  // SRAM model: an async SRAM latches the write when WE_n rises.
  logic [7:0] mem [logic [20:0]];
  int n_writes = 0;
  always @(posedge bus.sram_we_n) begin
    if (reset_n) begin
      mem[bus.sram_addr] = bus.sram_dout;
      n_writes++;
    end
  end

  task automatic next_cycle();
    @(posedge clk_chipset);
    @(negedge clk_chipset);
  endtask

  task automatic test_reset();
    logic [3:0] got;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.vid_req = 0; bus.vid_addr = '0; bus.sram_din = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk_chipset);
    got = {bus.sram_we_n, bus.sram_doe, bus.cpu_ack, bus.vid_ack};
    n_cmp++;
    if (got !== 4'b1000) begin
      $display("FAIL reset_ctrl actual=%b required=1000", got); n_bad++;
    end
    n_cmp++;
    if ({bus.sram_addr, bus.sram_dout} !== 29'd0) begin
      $display("FAIL reset_pins actual=%h/%h required=0/0", bus.sram_addr, bus.sram_dout); n_bad++;
    end
    n_cmp++;
    if ({bus.cpu_rdata, bus.vid_rdata, bus.busy} !== 17'd0) begin
      $display("FAIL reset_rdata actual=%h/%h busy=%b required=0/0/0",
               bus.cpu_rdata, bus.vid_rdata, bus.busy); n_bad++;
    end
    reset_n = 1'b1;
    next_cycle();
    next_cycle();
    n_cmp++;
    if (bus.busy !== 1'b0 || dut.r_state !== IDLE) begin
      $display("FAIL reset_idle actual busy=%b state=%0d required busy=0 state=IDLE",
               bus.busy, dut.r_state); n_bad++;
    end
  endtask

  task automatic test_cpu_write();
    logic [3:0] got, exp;
    int w0;
    w0 = n_writes;
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 21'h12345; bus.cpu_wdata = 8'hA5;
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      got = {bus.sram_we_n, bus.sram_doe, bus.cpu_ack, bus.busy};
      exp = {!(k == 2 || k == 3), (k <= 4), (k == 4), (k <= 4)};
      n_cmp++;
      if (got !== exp) begin
        $display("FAIL wr_ctrl cycle %0d actual we_n,doe,ack,busy=%b required=%b", k, got, exp); n_bad++;
      end
      if (k <= 4) begin
        n_cmp++;
        if (bus.sram_addr !== 21'h12345 || bus.sram_dout !== 8'hA5) begin
          $display("FAIL wr_pins cycle %0d actual=%h/%h required=12345/a5",
                   k, bus.sram_addr, bus.sram_dout); n_bad++;
        end
      end
      if (k == 4) bus.cpu_req = 0;
    end
    n_cmp++;
    if (n_writes - w0 != 1 || !mem.exists(21'h12345) || mem[21'h12345] !== 8'hA5) begin
      $display("FAIL wr_model actual writes=%0d required writes=1 data=a5", n_writes - w0); n_bad++;
    end
  endtask

  task automatic test_vid_read();
    logic [3:0] got, exp;
    bus.sram_din = 8'h3C;
    bus.vid_req = 1; bus.vid_addr = 21'h00100;
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      got = {bus.sram_we_n, bus.sram_doe, bus.vid_ack, bus.busy};
      exp = {1'b1, 1'b0, (k == 3), (k <= 2)};
      n_cmp++;
      if (got !== exp) begin
        $display("FAIL rd_ctrl cycle %0d actual we_n,doe,ack,busy=%b required=%b", k, got, exp); n_bad++;
      end
      if (k == 1) begin
        n_cmp++;
        if (bus.sram_addr !== 21'h00100) begin
          $display("FAIL rd_addr actual=%h required=00100", bus.sram_addr); n_bad++;
        end
      end
      if (k == 3) begin
        n_cmp++;
        if (bus.vid_rdata !== 8'h3C) begin
          $display("FAIL rd_data actual=%h required=3c", bus.vid_rdata); n_bad++;
        end
        bus.vid_req = 0;
      end
    end
    n_cmp++;
    if (bus.vid_rdata !== 8'h3C || bus.cpu_rdata !== 8'h00) begin
      $display("FAIL rd_hold actual vid=%h cpu=%h required vid=3c cpu=00",
               bus.vid_rdata, bus.cpu_rdata); n_bad++;
    end
  endtask

  task automatic test_priority_starve();
    string order;
    int guard;
    order = "";
    guard = 0;
    bus.sram_din = 8'h77;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 21'h00005;
    bus.vid_req = 1; bus.vid_addr = 21'h00200;
    while (order.len() < 6 && guard < 100) begin
      next_cycle();
      guard++;
      if (bus.vid_ack) order = {order, "V"};
      if (bus.cpu_ack) begin
        order = {order, "C"};
        bus.cpu_req = 0;
        n_cmp++;
        if (bus.cpu_rdata !== 8'h77) begin
          $display("FAIL starve_cpu_data actual=%h required=77", bus.cpu_rdata); n_bad++;
        end
      end
    end
    bus.vid_req = 0;
    bus.cpu_req = 0;
    n_cmp++;
    if (order != "VVVVCV") begin
      $display("FAIL starve_order actual=%s required=VVVVCV (cycles=%0d)", order, guard); n_bad++;
    end
    next_cycle();
    n_cmp++;
    if (dut.u_pick.r_cpu_wait !== 3'd0) begin
      $display("FAIL starve_wait_clear actual=%0d required=0", dut.u_pick.r_cpu_wait); n_bad++;
    end
    next_cycle();
  endtask

  task automatic test_write_ignore_change();
    int w0;
    w0 = n_writes;
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 21'h00AAA; bus.cpu_wdata = 8'h5A;
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      if (k >= 2 && k <= 4) begin
        n_cmp++;
        if (bus.sram_addr !== 21'h00AAA || bus.sram_dout !== 8'h5A) begin
          $display("FAIL chg_pins cycle %0d actual=%h/%h required=00aaa/5a",
                   k, bus.sram_addr, bus.sram_dout); n_bad++;
        end
      end
      if (k == 2) begin
        bus.cpu_addr = 21'h1FFFF; bus.cpu_wdata = 8'hFF;
      end
      if (k == 4) bus.cpu_req = 0;
    end
    n_cmp++;
    if (n_writes - w0 != 1 || mem.exists(21'h1FFFF) || mem[21'h00AAA] !== 8'h5A) begin
      $display("FAIL chg_model actual writes=%0d stray=%0d required writes=1 stray=0",
               n_writes - w0, mem.exists(21'h1FFFF)); n_bad++;
    end
  endtask

  task automatic test_reset_mid_write();
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 21'h00333; bus.cpu_wdata = 8'h11;
    next_cycle();
    @(posedge clk_chipset);
    #3;
    n_cmp++;
    if (bus.sram_we_n !== 1'b0) begin
      $display("FAIL rst_strobe_entry actual we_n=%b required=0", bus.sram_we_n); n_bad++;
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.sram_we_n !== 1'b1 || bus.sram_doe !== 1'b0) begin
      $display("FAIL rst_async actual we_n=%b doe=%b required we_n=1 doe=0",
               bus.sram_we_n, bus.sram_doe); n_bad++;
    end
    bus.cpu_req = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_chipset);
      n_cmp++;
      if (bus.cpu_ack !== 1'b0) begin
        $display("FAIL rst_no_ack actual=%b required=0", bus.cpu_ack); n_bad++;
      end
    end
    reset_n = 1'b1;
    next_cycle();
    n_cmp++;
    if (bus.busy !== 1'b0 || dut.r_state !== IDLE || bus.cpu_ack !== 1'b0) begin
      $display("FAIL rst_release actual busy=%b state=%0d ack=%b required 0/IDLE/0",
               bus.busy, dut.r_state, bus.cpu_ack); n_bad++;
    end
  endtask

  task automatic test_back_to_back();
    int acks[$];
    int w0;
    int k;
    w0 = n_writes;
    k = 0;
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 21'h00042; bus.cpu_wdata = 8'h99;
    while (acks.size() < 2 && k < 40) begin
      next_cycle();
      k++;
      if (bus.cpu_ack) begin
        acks.push_back(k);
        if (acks.size() == 2) bus.cpu_req = 0;
      end
    end
    bus.cpu_req = 0;
    n_cmp++;
    if (acks.size() != 2) begin
      $display("FAIL b2b_wr_timeout actual acks=%0d required=2", acks.size()); n_bad++;
    end else begin
      n_cmp++;
      if (acks[0] != 4 || acks[1] != 9) begin
        $display("FAIL b2b_wr_cycles actual=%0d,%0d required=4,9", acks[0], acks[1]); n_bad++;
      end
    end
    n_cmp++;
    if (n_writes - w0 != 2) begin
      $display("FAIL b2b_wr_count actual=%0d required=2", n_writes - w0); n_bad++;
    end
    next_cycle();
    next_cycle();
    acks.delete();
    k = 0;
    bus.vid_req = 1; bus.vid_addr = 21'h00777;
    while (acks.size() < 2 && k < 40) begin
      next_cycle();
      k++;
      if (bus.vid_ack) begin
        acks.push_back(k);
        if (acks.size() == 2) bus.vid_req = 0;
      end
    end
    bus.vid_req = 0;
    n_cmp++;
    if (acks.size() != 2) begin
      $display("FAIL b2b_rd_timeout actual acks=%0d required=2", acks.size()); n_bad++;
    end else begin
      n_cmp++;
      if (acks[0] != 3 || acks[1] != 7) begin
        $display("FAIL b2b_rd_cycles actual=%0d,%0d required=3,7", acks[0], acks[1]); n_bad++;
      end
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_vid_read();
    test_priority_starve();
    test_write_ignore_change();
    test_reset_mid_write();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
